// File: rtl/fetch_pkg.sv
// Shared types, default widths and helpers for the fetch controller.
// Used by fetch_ctrl and fetch_ras (the latter only under FETCH_RAS_EN).
package fetch_pkg;

   localparam int unsigned PcWDefault       = 8;
   localparam int unsigned OffWDefault      = 8;
   localparam int unsigned RasDepthDefault  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   // Sign-extends the low 'width' bits of val to 32 bits (width in 1..32).
   function automatic logic [31:0] sext32(input logic [31:0] val, input int unsigned width);
      logic signed [31:0] w_shl;
      logic signed [31:0] w_res;
      w_shl = $signed(val << (32 - width));
      w_res = w_shl >>> (32 - width);
      return $unsigned(w_res);
   endfunction

endpackage

// File: rtl/fetch_ras.sv
// Return-address stack: LIFO storage with occupancy count, full/empty flags,
// push/pop/clear controls and asynchronous active-low reset.
module fetch_ras
   import fetch_pkg::*;
#(
   parameter int unsigned Width = PcWDefault,
   parameter int unsigned Depth = RasDepthDefault
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [Width-1:0] i_data,
   output logic [Width-1:0] o_top,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW:0]    r_cnt;
   logic [PtrW-1:0]  w_wr_idx;
   logic [PtrW-1:0]  w_top_idx;

   assign w_wr_idx  = r_cnt[PtrW-1:0];
   assign w_top_idx = r_cnt[PtrW-1:0] - PtrW'(1);
   assign o_full    = (r_cnt == (PtrW+1)'(Depth));
   assign o_empty   = (r_cnt == '0);
   assign o_top     = r_mem[w_top_idx];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_push && !o_full) begin
         r_mem[w_wr_idx] <= i_data;
         r_cnt           <= r_cnt + 1'b1;
      end else if (i_pop && !o_empty) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter / next-instruction controller with IDLE/RUN/HALTED FSM.
// Define FETCH_RAS_EN to build the return-address stack for Call/Ret.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W      = PcWDefault,
   parameter int unsigned OFF_W     = OffWDefault,
   parameter int unsigned RAS_DEPTH = RasDepthDefault
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Branch,
   input  logic             BranchCond,
   input  logic             Jump,
   input  logic             Call,
   input  logic             Ret,
   input  logic [OFF_W-1:0] Offset,
   input  logic [PC_W-1:0]  Target,
   input  logic [PC_W-1:0]  Start_Addr,
   output logic [PC_W-1:0]  PC,
   output logic             Running,
   output logic             Done,
   output logic             StackErr
);

   fetch_state_e     r_state;
   fetch_state_e     w_state_d;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_pc_d;
   logic [PC_W-1:0]  w_pc_inc;
   logic [31:0]      w_off_ext32;
   logic [PC_W-1:0]  w_off_ext;

   assign w_pc_inc    = r_pc + PC_W'(1);
   assign w_off_ext32 = sext32(32'(Offset), OFF_W);
   assign w_off_ext   = w_off_ext32[PC_W-1:0];

`ifdef FETCH_RAS_EN
   logic            r_stack_err;
   logic            w_stack_err_d;
   logic            w_ras_push;
   logic            w_ras_pop;
   logic            w_ras_clear;
   logic            w_ras_full;
   logic            w_ras_empty;
   logic [PC_W-1:0] w_ras_top;

   fetch_ras #(
      .Width (PC_W),
      .Depth (RAS_DEPTH)
   ) u_ras (
      .i_clk   (CLK),
      .i_rst_n (Reset_n),
      .i_clear (w_ras_clear),
      .i_push  (w_ras_push),
      .i_pop   (w_ras_pop),
      .i_data  (w_pc_inc),
      .o_top   (w_ras_top),
      .o_full  (w_ras_full),
      .o_empty (w_ras_empty)
   );
`else
   logic w_unused_ret;
   assign w_unused_ret = Ret;
`endif

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
`ifdef FETCH_RAS_EN
      w_stack_err_d = r_stack_err;
      w_ras_push    = 1'b0;
      w_ras_pop     = 1'b0;
      w_ras_clear   = 1'b0;
`endif
      if (Start) begin
         w_state_d = RUN;
         w_pc_d    = Start_Addr;
`ifdef FETCH_RAS_EN
         w_ras_clear   = 1'b1;
         w_stack_err_d = 1'b0;
`endif
      end else if (r_state == RUN) begin
         if (Halt) begin
            w_state_d = HALTED;
`ifdef FETCH_RAS_EN
         end else if (Ret) begin
            if (!w_ras_empty) begin
               w_pc_d    = w_ras_top;
               w_ras_pop = 1'b1;
            end else begin
               w_pc_d        = w_pc_inc;
               w_stack_err_d = 1'b1;
            end
         end else if (Call) begin
            w_pc_d = Target;
            // A full stack keeps its existing entries; only the flag records the loss.
            if (!w_ras_full) begin
               w_ras_push = 1'b1;
            end else begin
               w_stack_err_d = 1'b1;
            end
`else
         end else if (Call) begin
            w_pc_d = Target;
`endif
         end else if (Jump) begin
            w_pc_d = Target;
         end else if (Branch || BranchCond) begin
            w_pc_d = r_pc + w_off_ext;
         end else begin
            w_pc_d = w_pc_inc;
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_pc    <= '0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
      end
   end

`ifdef FETCH_RAS_EN
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_stack_err <= 1'b0;
      end else begin
         r_stack_err <= w_stack_err_d;
      end
   end

   assign StackErr = r_stack_err;
`else
   assign StackErr = 1'b0;
`endif

   assign PC      = r_pc;
   assign Running = (r_state == RUN);
   assign Done    = (r_state == HALTED);

endmodule
